// File: rtl/cw_gap_decoder.sv
// rtl/cw_gap_decoder.sv - constant-weight gap list to serial binary decoder (recursive Golomb-Rice)
//
// Purpose:
//   Holds the T gap values of one constant-weight word (length 2^CW_W) and
//   turns them back into the serial binary message. Gap k is split with a
//   Rice parameter u derived from the remaining word length and weight:
//     u = max(0, msb(n_rem) - msb(t_rem)), q = gap >> u, r = gap mod 2^u
//   and is sent as q ones, a single zero, then the u bits of r MSB first.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_b     in   synchronous active-low reset
//   start     in   pulse in IDLE to decode the loaded block
//   msg_bype  in   gap value to store (CW_W bits)
//   wr_en     in   write strobe for msg_bype, honoured in IDLE only
//   bin_msg   out  serial message bit (0 whenever msg_rdy is low)
//   msg_rdy   out  bin_msg carries a message bit this cycle
//   msg_done  out  one-cycle pulse after the last bit of a block
module cw_gap_decoder #(
    parameter int CW_W = 16,
    parameter int T    = 9
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic [CW_W-1:0] msg_bype,
    input  logic            wr_en,
    output logic            bin_msg,
    output logic            msg_rdy,
    output logic            msg_done
);

    localparam int PTR_W = $clog2(T + 1);
    localparam int K_W   = (T > 1) ? $clog2(T) : 1;
    localparam int MSB_W = $clog2(CW_W + 2);

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(T);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(T - 1);
    localparam logic [CW_W:0]    N_INIT   = {1'b1, {CW_W{1'b0}}};
    localparam logic [MSB_W-1:0] U_MAX    = MSB_W'(CW_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_UNARY,
        S_ZERO,
        S_REM,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [CW_W-1:0]  buf_q [T];
    logic [CW_W:0]    n_rem_q;
    logic [PTR_W-1:0] t_rem_q;
    logic [K_W-1:0]   k_q;
    logic [MSB_W-1:0] u_q;
    logic [CW_W-1:0]  q_cnt_q;
    logic [CW_W-1:0]  r_sh_q;
    logic             bin_msg_q;
    logic             msg_rdy_q;
    logic             msg_done_q;

    // floor(log2 x); returns 0 for x == 0, which only arises for invalid
    // input after n_rem wraps and then simply forces u to 0.
    function automatic logic [MSB_W-1:0] msb_of(input logic [CW_W:0] x);
        logic [MSB_W-1:0] pos;
        pos = '0;
        for (int i = 0; i <= CW_W; i++) begin
            if (x[i]) begin
                pos = MSB_W'(i);
            end
        end
        return pos;
    endfunction

    logic [CW_W-1:0]  gap;
    logic [MSB_W-1:0] msb_n;
    logic [MSB_W-1:0] msb_t;
    logic [MSB_W-1:0] u_d;
    logic [MSB_W-1:0] r_shift;
    logic [CW_W-1:0]  q_d;
    logic [CW_W-1:0]  r_sh_d;
    logic [CW_W:0]    n_rem_d;
    logic             last_gap;

    always_comb begin
        gap      = buf_q[k_q];
        msb_n    = msb_of(n_rem_q);
        msb_t    = msb_of((CW_W + 1)'(t_rem_q));
        u_d      = (msb_n > msb_t) ? (msb_n - msb_t) : '0;
        r_shift  = U_MAX - u_d;
        q_d      = gap >> u_d;
        // Left-justify the remainder so REM can always emit the MSB and
        // shift; the top u bits are exactly gap mod 2^u.
        r_sh_d   = gap << r_shift;
        n_rem_d  = n_rem_q - {1'b0, gap} - (CW_W + 1)'(1);
        last_gap = (k_q == K_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            n_rem_q    <= '0;
            t_rem_q    <= '0;
            k_q        <= '0;
            u_q        <= '0;
            q_cnt_q    <= '0;
            r_sh_q     <= '0;
            bin_msg_q  <= 1'b0;
            msg_rdy_q  <= 1'b0;
            msg_done_q <= 1'b0;
            for (int i = 0; i < T; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            bin_msg_q  <= 1'b0;
            msg_rdy_q  <= 1'b0;
            msg_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // Writes stop at T entries; the pointer never wraps.
                    if (wr_en && (ptr_q < PTR_FULL)) begin
                        buf_q[ptr_q] <= msg_bype;
                        ptr_q        <= ptr_q + PTR_W'(1);
                    end
                    if (start) begin
                        n_rem_q <= N_INIT;
                        t_rem_q <= PTR_FULL;
                        k_q     <= '0;
                        state_q <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    u_q     <= u_d;
                    q_cnt_q <= q_d;
                    r_sh_q  <= r_sh_d;
                    state_q <= (q_d != '0) ? S_UNARY : S_ZERO;
                end

                S_UNARY: begin
                    bin_msg_q <= 1'b1;
                    msg_rdy_q <= 1'b1;
                    q_cnt_q   <= q_cnt_q - CW_W'(1);
                    if (q_cnt_q == CW_W'(1)) begin
                        state_q <= S_ZERO;
                    end
                end

                S_ZERO: begin
                    bin_msg_q <= 1'b0;
                    msg_rdy_q <= 1'b1;
                    if (u_q != '0) begin
                        state_q <= S_REM;
                    end else begin
                        n_rem_q <= n_rem_d;
                        t_rem_q <= t_rem_q - PTR_W'(1);
                        k_q     <= k_q + K_W'(1);
                        state_q <= last_gap ? S_DONE : S_SETUP;
                    end
                end

                S_REM: begin
                    bin_msg_q <= r_sh_q[CW_W-1];
                    msg_rdy_q <= 1'b1;
                    r_sh_q    <= r_sh_q << 1;
                    u_q       <= u_q - MSB_W'(1);
                    if (u_q == MSB_W'(1)) begin
                        n_rem_q <= n_rem_d;
                        t_rem_q <= t_rem_q - PTR_W'(1);
                        k_q     <= k_q + K_W'(1);
                        state_q <= last_gap ? S_DONE : S_SETUP;
                    end
                end

                S_DONE: begin
                    msg_done_q <= 1'b1;
                    ptr_q      <= '0;
                    state_q    <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bin_msg  = bin_msg_q;
    assign msg_rdy  = msg_rdy_q;
    assign msg_done = msg_done_q;

endmodule

// File: tb/tb_cw_gap_decoder.sv
// tb/tb_cw_gap_decoder.sv - self-checking bench for cw_gap_decoder
module tb_cw_gap_decoder;

    localparam int CW_W = 16;
    localparam int T    = 9;

    localparam int ENC_IDLE = 0;
    localparam int ENC_ZERO = 2;
    localparam int ENC_ONE  = 3;
    localparam int ENC_DONE = 4;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic            start = 1'b0;
    logic            wr_en = 1'b0;
    logic [CW_W-1:0] msg_bype = '0;
    logic            bin_msg;
    logic            msg_rdy;
    logic            msg_done;

    always #5 clk = ~clk;

    cw_gap_decoder #(.CW_W(CW_W), .T(T)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .msg_bype (msg_bype),
        .wr_en    (wr_en),
        .bin_msg  (bin_msg),
        .msg_rdy  (msg_rdy),
        .msg_done (msg_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int mdl_buf [T];
    int mdl_ptr;
    int exp_tl [$];
    int got_tl [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void mdl_reset();
        for (int i = 0; i < T; i++) mdl_buf[i] = 0;
        mdl_ptr = 0;
    endfunction

    function automatic void mdl_write(input int v);
        if (mdl_ptr < T) begin
            mdl_buf[mdl_ptr] = v;
            mdl_ptr++;
        end
    endfunction

    function automatic int flog2(input int x);
        int r;
        r = 0;
        while ((64'(1) << (r + 1)) <= 64'(x)) r++;
        return r;
    endfunction

    // Expected per-cycle output after each edge, starting with the start edge.
    function automatic void build_exp();
        int n, t, u, d;
        exp_tl.delete();
        exp_tl.push_back(ENC_IDLE);
        exp_tl.push_back(ENC_IDLE);
        n = 1 << CW_W;
        t = T;
        for (int k = 0; k < T; k++) begin
            if (k > 0) exp_tl.push_back(ENC_IDLE);
            d = mdl_buf[k];
            u = (n == 0) ? 0 : flog2(n) - flog2(t);
            if (u < 0) u = 0;
            for (int j = 0; j < (d >> u); j++) exp_tl.push_back(ENC_ONE);
            exp_tl.push_back(ENC_ZERO);
            for (int i = u - 1; i >= 0; i--)
                exp_tl.push_back(((d >> i) & 1) != 0 ? ENC_ONE : ENC_ZERO);
            n = (n - d - 1) & ((1 << (CW_W + 1)) - 1);
            t--;
        end
        exp_tl.push_back(ENC_DONE);
        exp_tl.push_back(ENC_IDLE);
        exp_tl.push_back(ENC_IDLE);
    endfunction

    // Length and packed value of the s-th run of msg_rdy in the capture.
    function automatic void seg(input int s, output int len, output int val);
        int run;
        bit prev, r;
        run = -1; prev = 0; len = 0; val = 0;
        foreach (got_tl[i]) begin
            r = (got_tl[i] & 2) != 0;
            if (r && !prev) run++;
            if (r && run == s) begin
                len++;
                val = (val << 1) | (got_tl[i] & 1);
            end
            prev = r;
        end
    endfunction

    task automatic load(input int vals [$]);
        foreach (vals[i]) begin
            wr_en    = 1'b1;
            msg_bype = vals[i][CW_W-1:0];
            mdl_write(vals[i]);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic run_block(input string tag, input bit noise, input int wr_last);
        int enc, after, done_idx, fd, mx;
        int first, nrdy, exp_rdy, runs, maxrun, cur, last, dcount, didx;
        bit r;
        if (wr_last >= 0) begin
            wr_en    = 1'b1;
            msg_bype = wr_last[CW_W-1:0];
            mdl_write(wr_last);
        end
        build_exp();
        done_idx = exp_tl.size() - 3;
        start = 1'b1;
        got_tl.delete();
        after = -1;
        for (int i = 0; i < 4000 && after != 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            enc = int'({msg_done, msg_rdy, bin_msg});
            got_tl.push_back(enc);
            if (after > 0) after--;
            else if (after < 0 && msg_done) after = 2;
            if (noise && (i + 1 <= done_idx)) begin
                start    = 1'($urandom_range(0, 1));
                wr_en    = 1'($urandom_range(0, 1));
                msg_bype = CW_W'($urandom);
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        mdl_ptr = 0;
        chk({tag, " finished in budget"}, int'(after == 0), 1);

        mx = (got_tl.size() > exp_tl.size()) ? got_tl.size() : exp_tl.size();
        fd = -1;
        for (int i = 0; i < mx; i++) begin
            if (i >= got_tl.size() || i >= exp_tl.size() || got_tl[i] != exp_tl[i]) begin
                fd = i;
                break;
            end
        end
        chk({tag, " stream first diff idx"}, fd, -1);

        first = -1; nrdy = 0; runs = 0; maxrun = 0; cur = 0; last = -1;
        dcount = 0; didx = -1; exp_rdy = 0;
        foreach (exp_tl[i]) if ((exp_tl[i] & 2) != 0) exp_rdy++;
        foreach (got_tl[i]) begin
            r = (got_tl[i] & 2) != 0;
            if (r) begin
                if (first < 0) first = i;
                nrdy++;
                if (last >= 0 && cur > 0) begin
                    runs++;
                    if (cur > maxrun) maxrun = cur;
                end
                cur = 0;
                last = i;
            end else begin
                cur++;
            end
            if ((got_tl[i] & 4) != 0) begin
                dcount++;
                didx = i;
            end
        end
        chk({tag, " first rdy edge"}, first, 2);
        chk({tag, " rdy count"}, nrdy, exp_rdy);
        chk({tag, " idle gaps"}, runs, T - 1);
        chk({tag, " idle gap max len"}, maxrun, 1);
        chk({tag, " done pulses"}, dcount, 1);
        chk({tag, " done after last bit"}, didx, last + 1);
    endtask

    int ex_gaps [$] = '{2058, 6766, 1261, 10504, 5711, 13502, 5971, 5852, 13249};

    initial begin
        int bad, len, val, runs, hit, rem, hi, d;
        bit seen, prev;
        int gq [$];

        // Reset held with inputs toggling.
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0 && (msg_rdy !== 1'b0 || bin_msg !== 1'b0 || msg_done !== 1'b0)) bad++;
            wr_en    = 1'(i & 1);
            start    = 1'((i >> 1) & 1);
            msg_bype = CW_W'($urandom);
        end
        @(negedge clk);
        if (msg_rdy !== 1'b0 || bin_msg !== 1'b0 || msg_done !== 1'b0) bad++;
        chk("reset outputs nonzero cycles", bad, 0);
        rst_b = 1'b1;
        wr_en = 1'b0;
        start = 1'b0;
        mdl_reset();
        @(negedge clk);

        // Empty buffer decodes as nine zero gaps.
        run_block("zeros", 0, -1);
        seg(0, len, val);
        chk("zeros gap0 len", len, 14);
        chk("zeros gap0 val", val, 0);
        seg(1, len, val);
        chk("zeros gap1 len", len, 13);

        // Reference vector with 29 surplus writes.
        gq = ex_gaps;
        for (int i = 0; i < 29; i++) gq.push_back(int'($urandom_range(0, 65535)));
        load(gq);
        run_block("example", 0, -1);
        seg(0, len, val);
        chk("example gap0 len", len, 14);
        chk("example gap0 val", val, 14'b00100000001010);
        seg(1, len, val);
        chk("example gap1 len", len, 14);
        chk("example gap1 val", val, 14'b10101001101110);

        // Large early gaps drive later Rice parameters to zero.
        load('{65000, 500, 26, 1, 0, 0, 0, 0, 0});
        run_block("u0", 0, -1);
        seg(3, len, val);
        chk("u0 gap3 len", len, 2);
        chk("u0 gap3 val", val, 2);
        seg(8, len, val);
        chk("u0 gap8 len", len, 1);

        // Reset during gap 3.
        load(ex_gaps);
        start = 1'b1;
        runs = 0; hit = 0; seen = 0; prev = 0;
        for (int i = 0; i < 2000 && hit == 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (msg_rdy) begin
                if (runs == 3) hit = 1;
                seen = 1;
            end else if (seen && prev) begin
                runs++;
            end
            prev = msg_rdy;
        end
        chk("midreset reached gap3", hit, 1);
        rst_b = 1'b0;
        @(negedge clk);
        chk("midreset outputs", int'({msg_done, msg_rdy, bin_msg}), 0);
        rst_b = 1'b1;
        mdl_reset();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (msg_rdy !== 1'b0 || msg_done !== 1'b0 || bin_msg !== 1'b0) bad++;
        end
        chk("midreset stays idle", bad, 0);
        load(ex_gaps);
        run_block("after midreset", 0, -1);

        // Random valid blocks with start/wr_en noise while busy.
        for (int b = 0; b < 8; b++) begin
            gq.delete();
            rem = (1 << CW_W) - T;
            for (int k = 0; k < T; k++) begin
                hi = (k == T - 1) ? rem : (rem * 2) / (T - k);
                if (hi > rem) hi = rem;
                if ($urandom_range(0, 3) == 0) hi = hi / 64;
                d = int'($urandom_range(0, hi));
                rem -= d;
                gq.push_back(d);
            end
            if (b % 2 == 1) begin
                d = gq.pop_back();
                load(gq);
                run_block($sformatf("rand%0d", b), 1, d);
            end else begin
                load(gq);
                run_block($sformatf("rand%0d", b), 1, -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cw_gap_decoder.md
Name: cw_gap_decoder

Overview:
- Constant-weight-word to binary decoder (m=16, t=9 variant).
- Accepts T gap values δ_0..δ_{T-1} of a constant-weight word of length n = 2^CW_W. Each gap is the distance between successive set positions.
- Converts the gaps to a serial binary message using recursive Golomb-Rice coding: the inverse of the binary→constant-weight encoder.
- Sits downstream of the word buffer and feeds a serial bit sink.

Parameters:
- CW_W, 16, gap width in bits; word length n = 2^CW_W.
- T, 9, number of gaps (weight) per block.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_b  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that begins decoding of the loaded block.
- msg_bype  in  CW_W  gap value to store.
- wr_en  in  1  write strobe for msg_bype.
- bin_msg  out  1  serial message bit.
- msg_rdy  out  1  bin_msg valid this cycle.
- msg_done  out  1  one-cycle pulse after the last bit of a block.

Behaviour:
- Reset (rst_b=0 at an edge):
  - State goes to IDLE; write pointer = 0; gap buffer cleared to 0.
  - bin_msg=0, msg_rdy=0, msg_done=0.
  - Applies mid-operation too: any decode in progress is abandoned.
- Load:
  - In IDLE, each edge with wr_en=1 stores msg_bype into buf[ptr], then ptr++.
  - Once ptr==T, further writes are ignored; there is no wrap.
  - wr_en is ignored outside IDLE.
- Start:
  - start=1 in IDLE launches decoding with n_rem = 2^CW_W (CW_W+1 bits wide), t_rem = T, k = 0.
  - If fewer than T words were loaded, the stored (possibly zero) contents are used.
  - start outside IDLE is ignored. If wr_en and start are high together in IDLE, the write is taken and decoding starts next cycle.
- States: IDLE → SETUP → UNARY → ZERO → REM → (SETUP for next gap | DONE) → IDLE.
- SETUP (1 cycle, msg_rdy=0):
  - u = max(0, msb(n_rem) − msb(t_rem)), where msb(x) = floor(log2 x).
  - q = δ_k >> u; r = δ_k mod 2^u.
- UNARY: emit q bits of value 1, one per cycle. Skipped when q=0.
- ZERO: emit a single 0.
- REM: emit the u bits of r, MSB first. Skipped when u=0.
- After REM (or ZERO when u=0):
  - n_rem ← n_rem − δ_k − 1; t_rem ← t_rem − 1; k++.
  - If k==T go to DONE, else go to SETUP.
- Output timing:
  - bin_msg and msg_rdy are registered. msg_rdy=1 exactly in the cycles where bin_msg carries a message bit.
  - First bit appears in the 2nd cycle after the start edge.
  - Exactly one idle (msg_rdy=0) SETUP cycle separates consecutive gaps.
  - Bits per gap = q + 1 + u.
- DONE: msg_done=1 for exactly one cycle after the final bit; ptr ← 0; return to IDLE. A new block can then be loaded.
- Valid input requires Σδ_i + T ≤ 2^CW_W. For invalid input the bit values are unspecified, but decoding must still terminate: q is bounded by δ_k >> u and arithmetic wraps in CW_W+1 bits.
- While not emitting, bin_msg holds 0.

Test Plan:
- Reset: hold rst_b=0 for 10 cycles with wr_en/start toggling → all outputs 0. After release, start with no writes decodes nine zero gaps:
  - gap0: u=13 → 14 zero bits.
  - Then n_rem=65535, t_rem=8: msb 15−3 → u=12 → 13 zeros.
  - Then msg_done.
- Load 2058, 6766, 1261, 10504, 5711, 13502, 5971, 5852, 13249, then 29 extra writes (ignored), then start:
  - gap0: u=13 → "0" then 0100000001010.
  - SETUP cycle; gap1: n_rem=63477, t=8 → u=12, q=1, r=2670 → "1","0", then 101001101110.
  - msg_done one cycle after the last bit.
- Timing: check the first msg_rdy lands 2 cycles after the start edge, exactly one msg_rdy=0 cycle between gaps, and the total msg_rdy count equals Σ(q_i+1+u_i).
- Gap with u=0 path: drive a small n_rem/large t_rem case by loading huge early gaps (δ_0=65000, …) → the later gap emits only unary+0 with no remainder bits.
- Reset mid-stream: pull rst_b low during gap 3 → next cycle outputs 0 and IDLE. Reload and restart → identical bitstream to the undisturbed run.
- Start pulsed again while busy, and wr_en while busy → no effect on the bitstream. After msg_done, a new load+start produces a fresh block.
